// File: rtl/demux_capture_bank_pkg.sv
// Shared constants for the demux capture bank: default widths, channel count
// and the channel select encoding used by the upstream demultiplexer.
package demux_capture_bank_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;
    localparam int NUM_CH     = 4;
    localparam int SEL_W      = 2;

    localparam logic [SEL_W-1:0] CH0 = 2'b00;
    localparam logic [SEL_W-1:0] CH1 = 2'b01;
    localparam logic [SEL_W-1:0] CH2 = 2'b10;
    localparam logic [SEL_W-1:0] CH3 = 2'b11;

endpackage

// File: rtl/demux_capture_bank_capture_chan.sv
// One capture channel: holding register, unread/overrun flags and a
// saturating capture counter.
module capture_chan
    import demux_capture_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] hold,
    output logic              full,
    output logic              ovf,
    output logic [CNT_W-1:0]  cnt
);

    logic [DATA_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic              ovf_q,  ovf_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    always_comb begin
        hold_d = hold_q;
        full_d = full_q;
        ovf_d  = ovf_clr ? 1'b0 : ovf_q;
        cnt_d  = cnt_q;
        if (rd) begin
            full_d = 1'b0;
        end
        if (wr) begin
            hold_d = wr_data;
            full_d = 1'b1;
            // A same-cycle read drains the old byte, so overwriting it is not an overrun
            if (full_q && !rd) begin
                ovf_d = 1'b1;
            end
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            full_q <= 1'b0;
            ovf_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            full_q <= full_d;
            ovf_q  <= ovf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign hold = hold_q;
    assign full = full_q;
    assign ovf  = ovf_q;
    assign cnt  = cnt_q;

endmodule

// File: rtl/demux_capture_bank.sv
// Capture bank behind the 4-way demux: select decode into four capture
// channels and a registered read mux back to the consumer.
module demux_capture_bank
    import demux_capture_bank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]       ch0_in,
    input  logic [DATA_W-1:0]       ch1_in,
    input  logic [DATA_W-1:0]       ch2_in,
    input  logic [DATA_W-1:0]       ch3_in,
    input  logic                    rd_en,
    input  logic [SEL_W-1:0]        rd_sel,
    input  logic                    ovf_clr,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [NUM_CH-1:0]       ch_full,
    output logic [NUM_CH-1:0]       ch_ovf,
    output logic [NUM_CH*CNT_W-1:0] ch_cnt
);

    logic [DATA_W-1:0] ch_in [NUM_CH];
    logic [DATA_W-1:0] hold  [NUM_CH];
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] rd_hit;

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    assign ch_in[0] = ch0_in;
    assign ch_in[1] = ch1_in;
    assign ch_in[2] = ch2_in;
    assign ch_in[3] = ch3_in;

    always_comb begin
        wr_hit = '0;
        rd_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = wr_en && (wr_sel == SEL_W'(i));
            rd_hit[i] = rd_en && (rd_sel == SEL_W'(i));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        capture_chan #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .wr      (wr_hit[i]),
            .wr_data (ch_in[i]),
            .rd      (rd_hit[i]),
            .ovf_clr (ovf_clr),
            .hold    (hold[i]),
            .full    (ch_full[i]),
            .ovf     (ch_ovf[i]),
            .cnt     (ch_cnt[i*CNT_W +: CNT_W])
        );
    end

    // An empty channel reads back as zero even though its holding register keeps stale data
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (rd_en) begin
            rd_valid_d = ch_full[rd_sel];
            rd_data_d  = ch_full[rd_sel] ? hold[rd_sel] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_demux_capture_bank.sv
// Bench for demux_capture_bank: directed scenarios plus random traffic,
// compared every cycle against a behavioural per-channel model.
module tb_demux_capture_bank;
    import demux_capture_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sel = '0;
    logic [7:0]  ch0_in = '0, ch1_in = '0, ch2_in = '0, ch3_in = '0;
    logic        rd_en = 1'b0;
    logic [1:0]  rd_sel = '0;
    logic        ovf_clr = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [3:0]  ch_full;
    logic [3:0]  ch_ovf;
    logic [15:0] ch_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    logic [7:0] m_hold [4];
    bit         m_full [4];
    bit         m_ovf  [4];
    int         m_cnt  [4];
    logic [7:0] m_rd_data;
    bit         m_rd_valid;

    demux_capture_bank dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .ch0_in   (ch0_in),
        .ch1_in   (ch1_in),
        .ch2_in   (ch2_in),
        .ch3_in   (ch3_in),
        .rd_en    (rd_en),
        .rd_sel   (rd_sel),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .ch_full  (ch_full),
        .ch_ovf   (ch_ovf),
        .ch_cnt   (ch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] chan_in(input int c);
        case (c)
            0: return ch0_in;
            1: return ch1_in;
            2: return ch2_in;
            default: return ch3_in;
        endcase
    endfunction

    // Apply one clock's worth of the bank's rules to the model, using the current inputs
    task automatic model_step();
        bit overrun;
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                m_hold[c] = '0; m_full[c] = 0; m_ovf[c] = 0; m_cnt[c] = 0;
            end
            m_rd_data  = '0;
            m_rd_valid = 0;
            return;
        end
        if (rd_en) begin
            m_rd_valid = m_full[rd_sel];
            m_rd_data  = m_full[rd_sel] ? m_hold[rd_sel] : 8'h00;
        end else begin
            m_rd_valid = 0;
        end
        overrun = wr_en && m_full[wr_sel] && !(rd_en && rd_sel == wr_sel);
        if (ovf_clr) for (int c = 0; c < 4; c++) m_ovf[c] = 0;
        if (rd_en) m_full[rd_sel] = 0;
        if (wr_en) begin
            m_hold[wr_sel] = chan_in(int'(wr_sel));
            m_full[wr_sel] = 1;
            m_cnt[wr_sel]  = (m_cnt[wr_sel] >= 15) ? 15 : m_cnt[wr_sel] + 1;
            if (overrun) m_ovf[wr_sel] = 1;
        end
    endtask

    task automatic check_all();
        logic [3:0]  e_full, e_ovf;
        logic [15:0] e_cnt;
        for (int c = 0; c < 4; c++) begin
            e_full[c] = m_full[c];
            e_ovf[c]  = m_ovf[c];
            e_cnt[c*4 +: 4] = 4'(m_cnt[c]);
        end
        check("rd_data",  32'(rd_data),  32'(m_rd_data));
        check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        check("ch_full",  32'(ch_full),  32'(e_full));
        check("ch_ovf",   32'(ch_ovf),   32'(e_ovf));
        check("ch_cnt",   32'(ch_cnt),   32'(e_cnt));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; rd_en = 0; ovf_clr = 0;
    endtask

    task automatic rand_data();
        ch0_in = 8'($urandom); ch1_in = 8'($urandom);
        ch2_in = 8'($urandom); ch3_in = 8'($urandom);
    endtask

    task automatic write(input logic [1:0] sel, input logic [7:0] val);
        rand_data();
        wr_en = 1; wr_sel = sel;
        case (sel)
            CH0: ch0_in = val;
            CH1: ch1_in = val;
            CH2: ch2_in = val;
            default: ch3_in = val;
        endcase
    endtask

    task automatic read(input logic [1:0] sel);
        rd_en = 1; rd_sel = sel;
    endtask

    initial begin
        // Reset with garbage on every input
        rst = 1; rand_data();
        wr_en = 1; rd_en = 1; ovf_clr = 0;
        wr_sel = 2'($urandom); rd_sel = 2'($urandom);
        cyc();
        rand_data(); wr_sel = 2'($urandom);
        cyc();
        check("rst_full", 32'(ch_full), 32'h0);
        check("rst_cnt",  32'(ch_cnt),  32'h0);
        check("rst_data", 32'(rd_data), 32'h0);

        // Empty read
        idle(); read(CH0); cyc();
        check("empty_valid", 32'(rd_valid), 32'h0);
        check("empty_data",  32'(rd_data),  32'h0);

        // Capture ch2 while ch0 input is busy
        idle(); write(CH2, 8'hA5); ch0_in = 8'hFF; cyc();
        check("cap_full", 32'(ch_full), 32'b0100);
        idle(); read(CH2); cyc();
        check("cap_data",  32'(rd_data),  32'hA5);
        check("cap_valid", 32'(rd_valid), 32'h1);
        check("cap_empty", 32'(ch_full),  32'h0);

        // Overrun on ch1, then clear
        idle(); write(CH1, 8'h11); cyc();
        idle(); write(CH1, 8'h22); cyc();
        check("ovr_flag", 32'(ch_ovf), 32'b0010);
        idle(); read(CH1); cyc();
        check("ovr_data", 32'(rd_data), 32'h22);
        idle(); ovf_clr = 1; cyc();
        check("ovr_clr", 32'(ch_ovf), 32'h0);

        // Same-cycle read and write on ch3
        idle(); write(CH3, 8'h33); cyc();
        idle(); write(CH3, 8'h44); read(CH3); cyc();
        check("rw_data",  32'(rd_data),    32'h33);
        check("rw_valid", 32'(rd_valid),   32'h1);
        check("rw_full",  32'(ch_full[3]), 32'h1);
        check("rw_ovf",   32'(ch_ovf[3]),  32'h0);
        idle(); read(CH3); cyc();
        check("rw_next", 32'(rd_data), 32'h44);

        // Saturation on ch0
        for (int i = 0; i < 20; i++) begin
            idle(); write(CH0, 8'(i)); cyc();
        end
        check("sat_cnt", 32'(ch_cnt[3:0]), 32'hF);
        check("sat_ovf", 32'(ch_ovf[0]),   32'h1);

        // Overrun coinciding with ovf_clr keeps that bit
        idle(); write(CH1, 8'h55); cyc();
        idle(); write(CH1, 8'h66); ovf_clr = 1; cyc();
        check("clr_race", 32'(ch_ovf), 32'b0010);

        // Fill all channels then reset mid-operation
        for (int c = 0; c < 4; c++) begin
            idle(); write(2'(c), 8'($urandom)); cyc();
        end
        check("fill_full", 32'(ch_full), 32'b1111);
        idle(); rst = 1; write(CH2, 8'h77); read(CH1); cyc();
        check("mid_full",  32'(ch_full),  32'h0);
        check("mid_ovf",   32'(ch_ovf),   32'h0);
        check("mid_cnt",   32'(ch_cnt),   32'h0);
        check("mid_valid", 32'(rd_valid), 32'h0);
        check("mid_data",  32'(rd_data),  32'h0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            rand_data();
            rst     = ($urandom_range(0, 59) == 0);
            wr_en   = $urandom_range(0, 1);
            wr_sel  = 2'($urandom);
            rd_en   = $urandom_range(0, 1);
            rd_sel  = 2'($urandom);
            ovf_clr = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_capture_bank.md
Name: demux_capture_bank

Overview:
- Sits directly downstream of the 4-way 8-bit demultiplexer. Takes the four channel outputs plus the same select code and a write strobe.
- On each strobe it captures the selected channel byte into a per-channel holding register.
- Tracks unread/overrun status per channel.
- A consumer reads channels back through a registered read port.

Parameters:
- DATA_W, 8, width of each channel byte.
- CNT_W, 4, width of each per-channel saturating capture counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  capture strobe, one capture per asserted cycle.
- wr_sel  input  2  channel select; same code that drives the demux sel.
- ch0_in  input  DATA_W  demux out0.
- ch1_in  input  DATA_W  demux out1.
- ch2_in  input  DATA_W  demux out2.
- ch3_in  input  DATA_W  demux out3.
- rd_en  input  1  read request.
- rd_sel  input  2  channel to read.
- ovf_clr  input  1  clears all overrun flags.
- rd_data  output  DATA_W  registered read data.
- rd_valid  output  1  rd_data holds unread data from a valid read.
- ch_full  output  4  bit i set: channel i holds unread data.
- ch_ovf  output  4  bit i set: channel i was overwritten while full (sticky).
- ch_cnt  output  4*CNT_W  per-channel capture count, channel 0 in the LSBs.

Behaviour:
- Reset, when rst=1 at a rising edge:
  - All holding registers, rd_data, rd_valid, ch_full, ch_ovf and ch_cnt go to 0.
  - rst has priority over every other input in that cycle.
- Capture, when wr_en=1 at an edge:
  - hold[wr_sel] <= ch{wr_sel}_in.
  - The other channels' inputs are ignored, even if non-zero.
  - ch_full[wr_sel] <= 1.
  - ch_cnt[wr_sel] increments and saturates at all-ones, with no wrap.
  - Capture latency is 1 cycle: ch_full and the data are visible the cycle after the strobe.
- Overrun:
  - A capture into a channel whose ch_full is already 1, and which is not being read that same cycle, sets ch_ovf[wr_sel].
  - The new data overwrites the old.
- Read, when rd_en=1:
  - Next cycle rd_data <= hold[rd_sel] and rd_valid <= ch_full[rd_sel].
  - ch_full[rd_sel] clears.
  - Reading an empty channel gives rd_valid=0 and rd_data=0; state is unchanged.
  - When rd_en=0: rd_valid <= 0 and rd_data keeps its last value.
- Simultaneous read and write, same channel:
  - The read returns the pre-capture data.
  - ch_full stays 1 because the new data is unread.
  - No overrun is flagged.
- Simultaneous read and write, different channels: both take effect independently.
- ovf_clr:
  - Clears all ch_ovf bits in that cycle.
  - An overrun occurring in the same cycle wins, so that bit stays set.
- ch_cnt is not cleared by reads or by ovf_clr; only rst clears it.
- No handshake back-pressure: the bank always accepts writes and reads.

Decomposition:
- Shared package holds:
  - DATA_W and CNT_W defaults.
  - Channel count constant NUM_CH=4.
  - Select width constant SEL_W=2.
  - Channel index localparams CH0..CH3 (matching the demux sel encoding 2'b00..2'b11).
- One natural sub-module, capture_chan: one channel's holding register, full/ovf flags and saturating counter. It is instantiated four times by a generate loop.
- The top level does select decode and the registered read mux.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0; ch_full=4'b0000, ch_cnt=0.
- Capture: wr_en=1, wr_sel=2, ch2_in=8'hA5, with ch0_in=8'hFF at the same time.
  - Expect ch_full=4'b0100 next cycle.
  - Then rd_en=1, rd_sel=2 -> next cycle rd_data=8'hA5, rd_valid=1, ch_full=4'b0000.
- Overrun: write ch1=8'h11, then ch1=8'h22 with no read.
  - Expect ch_ovf=4'b0010.
  - Read ch1 -> rd_data=8'h22.
  - Then ovf_clr=1 -> ch_ovf=4'b0000.
- Same-cycle read and write on ch3:
  - ch3 holds 8'h33; in one cycle write 8'h44 and read ch3.
  - Expect rd_data=8'h33, rd_valid=1, ch_full[3]=1, ch_ovf[3]=0.
  - A following read returns 8'h44.
- Empty read and saturation:
  - Read ch0 after reset -> rd_valid=0, rd_data=0.
  - Then 20 writes to ch0 -> ch_cnt[3:0]=4'hF, saturated with no wrap.
  - ch_ovf[0]=1.
- Reset mid-operation: ch_full=4'b1111 and ch_ovf nonzero, assert rst in the same cycle as wr_en and rd_en.
  - Expect everything 0 next cycle.
  - No capture and no rd_valid.
